// File: rtl/pi_digit_reader.sv
// pi_digit_reader
// Host-side reader for the pi digit ROM tile. It loads a 9-bit start index
// into the ROM in two serial beats, then steps the ROM one index at a time
// and samples its 7-segment output. Each pattern is decoded back to a hex
// nibble, and the nibbles are packed two to a byte on a valid/ready stream.
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   start                  one-cycle run request, honoured only when idle
//   start_index[8:0]       first ROM index to read
//   digit_count[9:0]       number of digits to read (0..512)
//   busy, done             run in progress / one-cycle end-of-run pulse
//   rom_in[7:0]            ROM io_in: [7:3] index chunk, [2] stream, [1] ROM reset
//   seg_in[7:0]            ROM io_out: [6:0] = gfedcba, [7] unused
//   out_data/valid/ready   packed digit bytes, first digit in [7:4]
//   out_last               marks the final byte of a run
//   seg_err                sticky flag for an unrecognised segment pattern
module pi_digit_reader #(
    parameter int SETTLE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] start_index,
    input  logic [9:0] digit_count,
    output logic       busy,
    output logic       done,
    output logic [7:0] rom_in,
    input  logic [7:0] seg_in,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       seg_err
);

    localparam int WCW = $clog2(SETTLE);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        WAIT,
        CAPTURE,
        STEP,
        OUT,
        DONE
    } state_t;

    state_t     state, state_next;
    logic [WCW-1:0] wait_cnt, wait_cnt_next;
    logic [8:0] idx_q, idx_next;
    logic [9:0] rem_q, rem_next;
    logic [6:0] seg_sample, seg_sample_next;
    logic [3:0] nib_hi, nib_hi_next;
    logic       have_hi, have_hi_next;
    logic [7:0] out_data_next;
    logic       out_valid_next, out_last_next, seg_err_next;
    logic       busy_next, done_next;
    logic [7:0] rom_in_next;
    logic [4:0] dec;

    // Bit 7 of the ROM output carries nothing the reader decodes.
    logic unused_seg_msb;
    assign unused_seg_msb = seg_in[7];

    // Segment pattern to {error, nibble}; unknown patterns read as 0 with error.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'h3F:   decode_seg = 5'h00;
            7'h06:   decode_seg = 5'h01;
            7'h5B:   decode_seg = 5'h02;
            7'h4F:   decode_seg = 5'h03;
            7'h66:   decode_seg = 5'h04;
            7'h6D:   decode_seg = 5'h05;
            7'h7D:   decode_seg = 5'h06;
            7'h07:   decode_seg = 5'h07;
            7'h7F:   decode_seg = 5'h08;
            7'h6F:   decode_seg = 5'h09;
            7'h77:   decode_seg = 5'h0A;
            7'h7C:   decode_seg = 5'h0B;
            7'h39:   decode_seg = 5'h0C;
            7'h5E:   decode_seg = 5'h0D;
            7'h79:   decode_seg = 5'h0E;
            7'h71:   decode_seg = 5'h0F;
            default: decode_seg = 5'h10;
        endcase
    endfunction

    // State register and every output register. All outputs come from here,
    // so nothing the ROM or the consumer sees is combinational.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            idx_q      <= '0;
            rem_q      <= '0;
            seg_sample <= '0;
            nib_hi     <= '0;
            have_hi    <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            seg_err    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rom_in     <= '0;
        end else begin
            state      <= state_next;
            wait_cnt   <= wait_cnt_next;
            idx_q      <= idx_next;
            rem_q      <= rem_next;
            seg_sample <= seg_sample_next;
            nib_hi     <= nib_hi_next;
            have_hi    <= have_hi_next;
            out_data   <= out_data_next;
            out_valid  <= out_valid_next;
            out_last   <= out_last_next;
            seg_err    <= seg_err_next;
            busy       <= busy_next;
            done       <= done_next;
            rom_in     <= rom_in_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next      = state;
        wait_cnt_next   = wait_cnt;
        idx_next        = idx_q;
        rem_next        = rem_q;
        seg_sample_next = seg_sample;
        nib_hi_next     = nib_hi;
        have_hi_next    = have_hi;
        out_data_next   = out_data;
        out_valid_next  = out_valid;
        out_last_next   = out_last;
        seg_err_next    = seg_err;
        dec             = decode_seg(seg_sample);

        case (state)
            IDLE: begin
                if (start) begin
                    idx_next     = start_index;
                    rem_next     = digit_count;
                    seg_err_next = 1'b0;
                    have_hi_next = 1'b0;
                    state_next   = (digit_count == 10'd0) ? DONE : LOAD_A;
                end
            end
            LOAD_A: state_next = LOAD_B;
            LOAD_B: begin
                wait_cnt_next = '0;
                state_next    = WAIT;
            end
            // The count starts when the stream/reset control drops, so the
            // sample lands SETTLE clocks after that registered change.
            WAIT: begin
                if (wait_cnt == WCW'(SETTLE - 1)) begin
                    seg_sample_next = seg_in[6:0];
                    state_next      = CAPTURE;
                end else begin
                    wait_cnt_next = wait_cnt + WCW'(1);
                end
            end
            CAPTURE: begin
                rem_next = rem_q - 10'd1;
                if (dec[4]) begin
                    seg_err_next = 1'b1;
                end
                if (have_hi) begin
                    out_data_next  = {nib_hi, dec[3:0]};
                    out_valid_next = 1'b1;
                    out_last_next  = (rem_q == 10'd1);
                    have_hi_next   = 1'b0;
                    state_next     = OUT;
                end else if (rem_q == 10'd1) begin
                    // Odd count: the lone final digit goes out with a zero pad.
                    out_data_next  = {dec[3:0], 4'h0};
                    out_valid_next = 1'b1;
                    out_last_next  = 1'b1;
                    state_next     = OUT;
                end else begin
                    nib_hi_next  = dec[3:0];
                    have_hi_next = 1'b1;
                    state_next   = STEP;
                end
            end
            STEP: begin
                wait_cnt_next = '0;
                state_next    = WAIT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    out_last_next  = 1'b0;
                    state_next     = (rem_q == 10'd0) ? DONE : STEP;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // done trails the DONE state by one clock; busy covers the whole run.
        busy_next = (state_next != IDLE);
        done_next = (state == DONE);

        // The two load beats shift the index in 5 bits at a time from the top:
        // the first beat parks S[3:0] in the upper bits, the second beat pushes
        // it down to [3:0] under S[8:4].
        case (state_next)
            LOAD_A:  rom_in_next = {idx_next[3:0], 1'b0, 3'b010};
            LOAD_B:  rom_in_next = {idx_next[8:4], 3'b010};
            STEP:    rom_in_next = 8'h04;
            default: rom_in_next = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_pi_digit_reader.sv
// Testbench for pi_digit_reader. A small ROM model (digit = index[3:0],
// segment output one register behind the index) drives seg_in. Expected
// bytes are queued when a run is started and compared at each handshake.
module tb_pi_digit_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] start_index;
    logic [9:0] digit_count;
    logic       busy;
    logic       done;
    logic [7:0] rom_in;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       seg_err;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];
    int done_seen   = 0;
    int stream_seen = 0;
    int rst_seen    = 0;
    int valid_seen  = 0;

    logic [8:0] rom_idx = '0;
    logic [7:0] rom_seg = '0;
    logic       bad_en  = 1'b0;
    logic [8:0] bad_idx = '0;

    always #5 clk = ~clk;

    pi_digit_reader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_index (start_index),
        .digit_count (digit_count),
        .busy        (busy),
        .done        (done),
        .rom_in      (rom_in),
        .seg_in      (rom_seg),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .seg_err     (seg_err)
    );

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'h0: enc = 7'h3F;
            4'h1: enc = 7'h06;
            4'h2: enc = 7'h5B;
            4'h3: enc = 7'h4F;
            4'h4: enc = 7'h66;
            4'h5: enc = 7'h6D;
            4'h6: enc = 7'h7D;
            4'h7: enc = 7'h07;
            4'h8: enc = 7'h7F;
            4'h9: enc = 7'h6F;
            4'hA: enc = 7'h77;
            4'hB: enc = 7'h7C;
            4'hC: enc = 7'h39;
            4'hD: enc = 7'h5E;
            4'hE: enc = 7'h79;
            default: enc = 7'h71;
        endcase
    endfunction

    // ROM model: serial index load while its reset is high, +1 on stream,
    // segment output registered one clock behind the index. Bit 7 is set on
    // good patterns so the reader must ignore it.
    always @(posedge clk) begin
        if (rom_in[1]) begin
            rom_idx <= {rom_in[7:3], rom_idx[8:5]};
        end else if (rom_in[2]) begin
            rom_idx <= rom_idx + 9'd1;
        end
        rom_seg <= (bad_en && rom_idx == bad_idx) ? 8'h00 : {1'b1, enc(rom_idx[3:0])};
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [8:0] s, input logic [9:0] n);
        @(posedge clk);
        #1;
        start_index = s;
        digit_count = n;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    initial begin
        logic [8:0] exp_byte;
        int base_done;
        int base_stream;
        int base_valid;
        int base_rst;

        reset       = 1'b1;
        start       = 1'b0;
        start_index = '0;
        digit_count = '0;
        out_ready   = 1'b1;

        // Event counters and scoreboard, sampled on the falling edge.
        fork
            forever begin
                @(negedge clk);
                if (done === 1'b1) done_seen++;
                if (rom_in[2] === 1'b1) stream_seen++;
                if (rom_in[1] === 1'b1) rst_seen++;
                if (out_valid === 1'b1) valid_seen++;
                if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_byte", 32'(exp_q.size()), 32'd1);
                    end else begin
                        exp_byte = exp_q.pop_front();
                        checkOutput("byte_data", 32'(out_data), 32'(exp_byte[7:0]));
                        checkOutput("byte_last", 32'(out_last), 32'(exp_byte[8]));
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs",
                    32'({busy, done, rom_in, out_data, out_valid, out_last, seg_err}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Even count from index 5.
        exp_q.push_back(9'h056);
        exp_q.push_back(9'h178);
        base_done = done_seen;
        applyStimulus(9'h005, 10'd4);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        waitDone("t1_done", 200);
        checkOutput("t1_drained", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("t1_one_done", 32'(done_seen - base_done), 32'd1);
        checkOutput("t1_idle", 32'(busy), 32'd0);

        // Load beat encoding for index 0x0A3.
        exp_q.push_back(9'h134);
        applyStimulus(9'h0A3, 10'd2);
        checkOutput("t4_load_a_chunk", 32'(rom_in[7:3]), 32'h06);
        checkOutput("t4_load_a_ctl", 32'(rom_in[2:0]), 32'h2);
        @(posedge clk);
        #1;
        checkOutput("t4_load_b_chunk", 32'(rom_in[7:3]), 32'h0A);
        checkOutput("t4_load_b_ctl", 32'(rom_in[2:0]), 32'h2);
        waitDone("t4_done", 200);
        checkOutput("t4_drained", 32'(exp_q.size()), 32'd0);

        // Wrap 511->0, odd count, plus a start pulse while busy that must be ignored.
        exp_q.push_back(9'h0EF);
        exp_q.push_back(9'h100);
        base_done = done_seen;
        applyStimulus(9'h1FE, 10'd3);
        repeat (4) @(posedge clk);
        #1;
        start_index = 9'h000;
        digit_count = 10'd0;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("t2_busy_after_ignored_start", 32'(busy), 32'd1);
        waitDone("t2_done", 200);
        checkOutput("t2_drained", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("t2_one_done", 32'(done_seen - base_done), 32'd1);

        // Zero-length run.
        base_done  = done_seen;
        base_valid = valid_seen;
        base_rst   = rst_seen;
        applyStimulus(9'h123, 10'd0);
        checkOutput("t3_done_not_yet", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("t3_done_pulse", 32'(done), 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("t3_one_done", 32'(done_seen - base_done), 32'd1);
        checkOutput("t3_no_valid", 32'(valid_seen - base_valid), 32'd0);
        checkOutput("t3_no_rom_reset", 32'(rst_seen - base_rst), 32'd0);

        // Consumer stall on the first byte.
        out_ready = 1'b0;
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h123);
        applyStimulus(9'h020, 10'd4);
        for (int n = 0; n < 100 && out_valid !== 1'b1; n++) @(negedge clk);
        checkOutput("t5_valid", 32'(out_valid), 32'd1);
        base_stream = stream_seen;
        repeat (10) begin
            @(negedge clk);
            checkOutput("t5_stall_data", 32'(out_data), 32'h01);
            checkOutput("t5_stall_valid", 32'(out_valid), 32'd1);
        end
        checkOutput("t5_no_stream", 32'(stream_seen - base_stream), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitDone("t5_done", 200);
        checkOutput("t5_drained", 32'(exp_q.size()), 32'd0);

        // Bad pattern on the second digit, then reset in the middle of WAIT.
        bad_en  = 1'b1;
        bad_idx = 9'h014;
        exp_q.push_back(9'h130);
        applyStimulus(9'h013, 10'd2);
        waitDone("t6_done", 200);
        checkOutput("t6_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("t6_seg_err", 32'(seg_err), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("t6_seg_err_sticky", 32'(seg_err), 32'd1);
        bad_en = 1'b0;
        applyStimulus(9'h040, 10'd4);
        checkOutput("t6_err_cleared_by_start", 32'(seg_err), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset      = 1'b1;
        base_done  = done_seen;
        base_valid = valid_seen;
        @(posedge clk);
        #1;
        checkOutput("t6_reset_outputs",
                    32'({busy, done, rom_in, out_data, out_valid, out_last, seg_err}), 32'd0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("t6_no_done", 32'(done_seen - base_done), 32'd0);
        checkOutput("t6_no_valid", 32'(valid_seen - base_valid), 32'd0);
        checkOutput("t6_idle", 32'(busy), 32'd0);

        // Single digit after reset: top index, pad nibble.
        exp_q.push_back(9'h1F0);
        applyStimulus(9'h1FF, 10'd1);
        waitDone("t7_done", 200);
        checkOutput("t7_drained", 32'(exp_q.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
